// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N_TERMS unsigned products from the multiplier into one
// saturating dot-product result and offers it downstream over valid/ready.
// Sequence per result: IDLE (first term) -> ACCUM (remaining terms) -> DONE
// (result held until consumed). clear aborts the result and rst reinitialises
// the block; rst takes priority over clear.
module mac_accumulator #(
    parameter int SIZE_C  = 4,
    parameter int ACC_W   = 2*SIZE_C+2,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*SIZE_C-1:0]   prod,
    input  logic                  prod_valid,
    output logic                  in_ready,
    input  logic                  clear,
    output logic [ACC_W-1:0]      acc_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic [CNT_W-1:0]      term_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Term count of the final product in a result.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;
    // Number of zero bits that pad the product up to the ACC_W+1 wide sum.
    localparam int PAD_W = ACC_W + 1 - 2*SIZE_C;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   sum;
    logic [CNT_W-1:0] cnt_inc;

    // One extra bit on the sum is enough: acc <= 2**ACC_W-1 and the product
    // fits in ACC_W bits, so the carry out flags saturation exactly.
    assign sum     = {1'b0, acc_q} + {{PAD_W{1'b0}}, prod};
    assign cnt_inc = cnt_q + ONE_CNT;

    // Next-state and datapath update; clear outranks any handshake activity.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First term loads the accumulator instead of adding to it.
                    if (prod_valid) begin
                        acc_d   = ACC_W'(prod);
                        cnt_d   = ONE_CNT;
                        ovf_d   = 1'b0;
                        state_d = (LAST_CNT == ONE_CNT) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    // Gaps in prod_valid simply hold every register.
                    if (prod_valid) begin
                        if (sum[ACC_W]) begin
                            acc_d = ACC_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_W-1:0];
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // Products are not accepted here, even on the handoff edge.
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign overflow  = ovf_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Testbench for mac_accumulator: an N_TERMS=8 instance and an N_TERMS=1
// instance. Expected results are pushed to a scoreboard when the terms are
// driven and popped when the DUT presents out_valid.
module tb_mac_accumulator;

    localparam int SIZE_C = 4;
    localparam int ACC_W  = 10;
    localparam int CNT_W  = 4;
    localparam int MAXV   = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N_TERMS = 8 instance
    logic             rst = 1'b0, clear = 1'b0, prod_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]       prod = '0;
    logic             in_ready, out_valid, overflow;
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] term_cnt;

    // N_TERMS = 1 instance
    logic             rst_1 = 1'b0, clear_1 = 1'b0, prod_valid_1 = 1'b0, out_ready_1 = 1'b0;
    logic [7:0]       prod_1 = '0;
    logic             in_ready_1, out_valid_1, overflow_1;
    logic [ACC_W-1:0] acc_out_1;
    logic [CNT_W-1:0] term_cnt_1;

    mac_accumulator #(.SIZE_C(SIZE_C), .ACC_W(ACC_W), .N_TERMS(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .prod(prod), .prod_valid(prod_valid), .in_ready(in_ready),
        .clear(clear), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .term_cnt(term_cnt)
    );

    mac_accumulator #(.SIZE_C(SIZE_C), .ACC_W(ACC_W), .N_TERMS(1), .CNT_W(CNT_W)) dut_1 (
        .clk(clk), .rst(rst_1), .prod(prod_1), .prod_valid(prod_valid_1), .in_ready(in_ready_1),
        .clear(clear_1), .acc_out(acc_out_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
        .overflow(overflow_1), .term_cnt(term_cnt_1)
    );

    typedef struct {
        int acc;
        bit ovf;
    } exp_t;

    exp_t sb[$];
    exp_t sb_1[$];
    int   checks   = 0;
    int   failures = 0;

    // Advance to just after the next rising edge; outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product for exactly one edge on the 8-term instance.
    task automatic feed(input int p);
        prod       = 8'(p);
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; rst_1 = 1'b1;
        tick(); tick();
        rst = 1'b0; rst_1 = 1'b0;
        checks++; if (acc_out !== 10'd0)  begin failures++; $display("FAIL reset_acc: got %0d expected 0", acc_out); end
        checks++; if (term_cnt !== 4'd0)  begin failures++; $display("FAIL reset_cnt: got %0d expected 0", term_cnt); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        // Three terms of five, then reset with a product still offered.
        for (int i = 0; i < 3; i++) feed(5);
        checks++; if (term_cnt !== 4'd3) begin failures++; $display("FAIL mid_cnt: got %0d expected 3", term_cnt); end
        checks++; if (acc_out !== 10'd15) begin failures++; $display("FAIL mid_acc: got %0d expected 15", acc_out); end
        rst = 1'b1; prod = 8'd5; prod_valid = 1'b1;
        tick();
        rst = 1'b0; prod_valid = 1'b0;
        checks++; if (acc_out !== 10'd0)  begin failures++; $display("FAIL midrst_acc: got %0d expected 0", acc_out); end
        checks++; if (term_cnt !== 4'd0)  begin failures++; $display("FAIL midrst_cnt: got %0d expected 0", term_cnt); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL midrst_in_ready: got %0b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); end
        e.acc = 0; // keep e referenced for a uniform task shape
    endtask

    task automatic test_basic();
        exp_t e;
        out_ready = 1'b1;
        e.acc = 36; e.ovf = 1'b0; sb.push_back(e);
        for (int i = 1; i <= 8; i++) feed(i);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency: out_valid got %0b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL basic_in_ready: got %0b expected 0", in_ready); end
        checks++; if (term_cnt !== 4'd8)  begin failures++; $display("FAIL basic_cnt: got %0d expected 8", term_cnt); end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (int'(acc_out) !== e.acc)  begin failures++; $display("FAIL basic_acc: got %0d expected %0d", acc_out, e.acc); end
            checks++; if (overflow !== e.ovf)       begin failures++; $display("FAIL basic_ovf: got %0b expected %0b", overflow, e.ovf); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_valid: got %0b expected 0", out_valid); end
        checks++; if (acc_out !== 10'd0)  begin failures++; $display("FAIL basic_idle_acc: got %0d expected 0", acc_out); end
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL basic_idle_in_ready: got %0b expected 1", in_ready); end
        $display("basic: 1..8 -> 36 done");
    endtask

    task automatic test_saturation();
        exp_t e;
        out_ready = 1'b0;
        e.acc = MAXV; e.ovf = 1'b1; sb.push_back(e);
        for (int i = 0; i < 5; i++) feed(225);
        // 5*225 = 1125 already exceeds 1023.
        checks++; if (acc_out !== 10'd1023) begin failures++; $display("FAIL sat_mid_acc: got %0d expected 1023", acc_out); end
        checks++; if (overflow !== 1'b1)    begin failures++; $display("FAIL sat_mid_ovf: got %0b expected 1", overflow); end
        for (int i = 0; i < 3; i++) feed(225);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat_valid: got %0b expected 1", out_valid); end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (int'(acc_out) !== e.acc) begin failures++; $display("FAIL sat_acc: got %0d expected %0d", acc_out, e.acc); end
            checks++; if (overflow !== e.ovf)      begin failures++; $display("FAIL sat_ovf: got %0b expected %0b", overflow, e.ovf); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sat_consume_ovf: got %0b expected 0", overflow); end
        e.acc = 8; e.ovf = 1'b0; sb.push_back(e);
        for (int i = 0; i < 8; i++) feed(1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat_next_valid: got %0b expected 1", out_valid); end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (int'(acc_out) !== e.acc) begin failures++; $display("FAIL sat_next_acc: got %0d expected %0d", acc_out, e.acc); end
            checks++; if (overflow !== e.ovf)      begin failures++; $display("FAIL sat_next_ovf: got %0b expected %0b", overflow, e.ovf); end
        end
        tick();
        $display("saturation: 8x225 -> 1023 ovf, then 8x1 -> 8 done");
    endtask

    task automatic test_gaps();
        exp_t e;
        int   got;
        out_ready = 1'b0;
        got = 0;
        e.acc = 80; e.ovf = 1'b0; sb.push_back(e);
        for (int c = 0; c < 40 && got < 8; c++) begin
            prod       = 8'd10;
            prod_valid = (c % 3 != 1);
            if (prod_valid) got++;
            tick();
            checks++; if (int'(term_cnt) !== got) begin failures++; $display("FAIL gap_cnt c=%0d: got %0d expected %0d", c, term_cnt, got); end
        end
        prod_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gap_valid: got %0b expected 1", out_valid); end
        // Products offered while DONE must be ignored.
        prod = 8'd99; prod_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== 10'd80 || term_cnt !== 4'd8) begin
                failures++;
                $display("FAIL gap_hold i=%0d: got rdy=%0b vld=%0b acc=%0d cnt=%0d expected 0 1 80 8", i, in_ready, out_valid, acc_out, term_cnt);
            end
        end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (int'(acc_out) !== e.acc) begin failures++; $display("FAIL gap_acc: got %0d expected %0d", acc_out, e.acc); end
        end
        // Handoff edge: prod_valid still high, nothing may be accepted.
        out_ready = 1'b1;
        tick();
        prod_valid = 1'b0;
        checks++; if (term_cnt !== 4'd0 || acc_out !== 10'd0) begin failures++; $display("FAIL gap_handoff: got cnt=%0d acc=%0d expected 0 0", term_cnt, acc_out); end
        $display("gaps: 8x10 with gaps -> 80 held until consumed");
    endtask

    task automatic test_clear();
        exp_t e;
        int   sum;
        int   p;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed(3);
        clear = 1'b1; prod = 8'd50; prod_valid = 1'b1;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        checks++; if (acc_out !== 10'd0 || term_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_accum: got acc=%0d cnt=%0d vld=%0b rdy=%0b expected 0 0 0 1", acc_out, term_cnt, out_valid, in_ready);
        end
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            p = int'($urandom_range(0, 120));
            sum += p;
            feed(p);
            if (i == 7) begin
                e.acc = (sum > MAXV) ? MAXV : sum; e.ovf = (sum > MAXV); sb.push_back(e);
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clear_fresh_valid: got %0b expected 1", out_valid); end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (int'(acc_out) !== e.acc) begin failures++; $display("FAIL clear_fresh_acc: got %0d expected %0d", acc_out, e.acc); end
        end
        tick();
        // clear while DONE drops the pending result.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (out_valid !== 1'b0 || acc_out !== 10'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL clear_done: got vld=%0b acc=%0d rdy=%0b expected 0 0 1", out_valid, acc_out, in_ready);
        end
        $display("clear: abort mid-accum and in DONE done");
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   sum;
        int   ovf;
        int   p;
        int   phase;
        out_ready = 1'b1;
        sum = 0; ovf = 0;
        for (int k = 0; k < 27; k++) begin
            phase = k % 9;
            p = int'($urandom_range(0, 225));
            prod = 8'(p); prod_valid = 1'b1;
            if (phase < 8) begin
                if (phase == 0) begin sum = p; ovf = 0; end
                else begin
                    sum += p;
                    if (sum > MAXV) begin sum = MAXV; ovf = 1; end
                end
                if (phase == 7) begin e.acc = sum; e.ovf = (ovf != 0); sb.push_back(e); end
            end
            tick();
            checks++; if (out_valid !== (phase == 7)) begin failures++; $display("FAIL b2b_valid k=%0d: got %0b expected %0b", k, out_valid, phase == 7); end
            if (out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (int'(acc_out) !== e.acc || overflow !== e.ovf) begin
                    failures++;
                    $display("FAIL b2b_result k=%0d: got acc=%0d ovf=%0b expected %0d %0b", k, acc_out, overflow, e.acc, e.ovf);
                end
            end
        end
        prod_valid = 1'b0;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d unconsumed expected 0", sb.size()); end
        $display("back_to_back: 3 results at 9-cycle period done");
    endtask

    task automatic test_single_term();
        exp_t e;
        out_ready_1 = 1'b0;
        e.acc = 200; e.ovf = 1'b0; sb_1.push_back(e);
        prod_1 = 8'd200; prod_valid_1 = 1'b1;
        tick();
        prod_valid_1 = 1'b0;
        checks++; if (out_valid_1 !== 1'b1) begin failures++; $display("FAIL n1_valid: got %0b expected 1", out_valid_1); end
        checks++; if (term_cnt_1 !== 4'd1)  begin failures++; $display("FAIL n1_cnt: got %0d expected 1", term_cnt_1); end
        if (out_valid_1 === 1'b1 && sb_1.size() > 0) begin
            e = sb_1.pop_front();
            checks++; if (int'(acc_out_1) !== e.acc) begin failures++; $display("FAIL n1_acc: got %0d expected %0d", acc_out_1, e.acc); end
        end
        // rst together with clear (and a product offered).
        rst_1 = 1'b1; clear_1 = 1'b1; prod_valid_1 = 1'b1;
        tick();
        rst_1 = 1'b0; clear_1 = 1'b0; prod_valid_1 = 1'b0;
        checks++; if (acc_out_1 !== 10'd0 || term_cnt_1 !== 4'd0 || out_valid_1 !== 1'b0 || overflow_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
            failures++;
            $display("FAIL n1_rst_clear: got acc=%0d cnt=%0d vld=%0b ovf=%0b rdy=%0b expected 0 0 0 0 1", acc_out_1, term_cnt_1, out_valid_1, overflow_1, in_ready_1);
        end
        // Same again with rst alone.
        prod_valid_1 = 1'b1;
        tick();
        checks++; if (out_valid_1 !== 1'b1) begin failures++; $display("FAIL n1_second_valid: got %0b expected 1", out_valid_1); end
        rst_1 = 1'b1;
        tick();
        rst_1 = 1'b0; prod_valid_1 = 1'b0;
        checks++; if (acc_out_1 !== 10'd0 || term_cnt_1 !== 4'd0 || out_valid_1 !== 1'b0 || overflow_1 !== 1'b0 || in_ready_1 !== 1'b1) begin
            failures++;
            $display("FAIL n1_rst_only: got acc=%0d cnt=%0d vld=%0b ovf=%0b rdy=%0b expected 0 0 0 0 1", acc_out_1, term_cnt_1, out_valid_1, overflow_1, in_ready_1);
        end
        $display("single_term: 200 -> 200, rst+clear equals rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gaps();
        test_clear();
        test_back_to_back();
        test_single_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
